// File: rtl/csi_packet_parser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi_packet_parser_pkg                                                    |
// | Shared constants, state encoding and header field helpers for CSI-2 RX.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package csi_packet_parser_pkg;

  localparam int         c_data_w      = 16;
  localparam int         c_ph_w        = 24;
  localparam int         c_ecc_w       = 6;
  localparam logic [7:0] c_long_dt_min = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // First header word is {WC_lo, DI}; second is {ECC, WC_hi}.
  function automatic logic [7:0] di_field(input logic [15:0] first_word);
    return first_word[7:0];
  endfunction

  function automatic logic [15:0] wc_field(input logic [15:0] first_word,
                                           input logic [15:0] second_word);
    return {second_word[7:0], first_word[15:8]};
  endfunction

  function automatic logic [5:0] ecc_field(input logic [15:0] second_word);
    return second_word[13:8];
  endfunction

  function automatic logic is_long_dt(input logic [7:0] di,
                                      input logic [7:0] long_min);
    return {2'b00, di[5:0]} >= long_min;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi_packet_parser_ph_ecc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi_ph_ecc                                                               |
// | Combinational CSI-2 packet-header ECC: 24 header bits -> 6 parity bits.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csi_ph_ecc
  import csi_packet_parser_pkg::*;
(
  input  logic [c_ph_w-1:0]  ph,
  output logic [c_ecc_w-1:0] ecc
);

  // Each parity bit covers the header bits whose Hamming column has that bit set.
  localparam logic [c_ph_w-1:0] c_ecc_mask [c_ecc_w] = '{
    24'hF12CB7,
    24'hF2555B,
    24'h749A6D,
    24'hB8E38E,
    24'hDF03F0,
    24'hEFFC00
  };

  for (genvar i = 0; i < c_ecc_w; i++) begin : g_parity
    assign ecc[i] = ^(ph & c_ecc_mask[i]);
  end

endmodule
`default_nettype wire

// File: rtl/csi_packet_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi_packet_parser                                                        |
// | Splits merged CSI-2 HS words into a checked packet header and payload.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csi_packet_parser
  import csi_packet_parser_pkg::*;
#(
  parameter int         DATA_STREAM_WIDTH = c_data_w,
  parameter int         PH_STREAM_WIDTH   = c_ph_w,
  parameter logic [7:0] LONG_DT_MIN       = c_long_dt_min
) (
  input  logic                         rxbyteclkhs,
  input  logic                         reset,
  input  logic [DATA_STREAM_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic [DATA_STREAM_WIDTH-1:0] data_stream,
  output logic [PH_STREAM_WIDTH-1:0]   ph_stream,
  output logic                         ph_select,
  output logic                         valid_stream,
  output logic                         ecc_error,
  output logic                         data_last,
  output logic                         data_half,
  output logic                         trunc_error
);

  state_t        r_state;
  logic [15:0]   r_hdr_lo;
  logic [15:0]   r_rem;

  logic [c_ph_w-1:0]  w_header;
  logic [c_ecc_w-1:0] w_ecc_calc;
  logic               w_ecc_bad;
  logic [15:0]        w_wc;
  logic               w_is_long;

  assign w_wc      = wc_field(r_hdr_lo, in_data);
  assign w_header  = {w_wc, di_field(r_hdr_lo)};
  assign w_ecc_bad = |(w_ecc_calc ^ ecc_field(in_data));
  assign w_is_long = is_long_dt(di_field(r_hdr_lo), LONG_DT_MIN);

  csi_ph_ecc u_ph_ecc (
    .ph  (w_header),
    .ecc (w_ecc_calc)
  );

  always_ff @(posedge rxbyteclkhs or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hdr_lo     <= '0;
      r_rem        <= '0;
      data_stream  <= '0;
      ph_stream    <= '0;
      ph_select    <= 1'b0;
      valid_stream <= 1'b0;
      ecc_error    <= 1'b0;
      data_last    <= 1'b0;
      data_half    <= 1'b0;
      trunc_error  <= 1'b0;
    end else begin
      // Qualifiers are single-cycle; the data buses simply hold.
      ph_select    <= 1'b0;
      valid_stream <= 1'b0;
      ecc_error    <= 1'b0;
      data_last    <= 1'b0;
      data_half    <= 1'b0;
      trunc_error  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_hdr_lo <= in_data;
            r_state  <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (!in_valid) begin
            trunc_error <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            ph_stream    <= w_header;
            ph_select    <= 1'b1;
            valid_stream <= 1'b1;
            ecc_error    <= w_ecc_bad;
            if (w_ecc_bad || !w_is_long) begin
              r_state <= ST_DRAIN;
            end else if (w_wc == 16'd0) begin
              r_state <= ST_CRC;
            end else begin
              r_rem   <= w_wc;
              r_state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!in_valid) begin
            trunc_error <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            data_stream  <= in_data;
            valid_stream <= 1'b1;
            if (r_rem > 16'd2) begin
              r_rem <= r_rem - 16'd2;
            end else begin
              // A single remaining byte means the upper lane already carries CRC_lo.
              data_last <= 1'b1;
              data_half <= r_rem[0];
              r_state   <= ST_CRC;
            end
          end
        end

        ST_CRC: begin
          if (!in_valid) begin
            trunc_error <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (!in_valid) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csi_packet_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csi_packet_parser                                                     |
// | Directed bursts checked every cycle against a burst-level packet model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_csi_packet_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] data_stream;
  logic [23:0] ph_stream;
  logic        ph_select, valid_stream, ecc_error, data_last, data_half, trunc_error;

  csi_packet_parser dut (
    .rxbyteclkhs  (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .data_stream  (data_stream),
    .ph_stream    (ph_stream),
    .ph_select    (ph_select),
    .valid_stream (valid_stream),
    .ecc_error    (ecc_error),
    .data_last    (data_last),
    .data_half    (data_half),
    .trunc_error  (trunc_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic        phs;
    logic        ecc;
    logic        last;
    logic        half;
    logic        trunc;
    logic [23:0] ph;
    logic [15:0] data;
  } exp_t;

  // Hamming column (syndrome) of each header bit.
  localparam logic [5:0] COL [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  exp_t        exp_q[$];
  exp_t        cur;
  logic [15:0] bw [0:31];
  exp_t        be [0:32];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [5:0] ecc_ref(input logic [23:0] h);
    logic [5:0] s = '0;
    for (int i = 0; i < 24; i++) if (h[i]) s ^= COL[i];
    return s;
  endfunction

  // Expected output for each of the n burst words plus the EoT cycle (slot n).
  task automatic compute_model(input int n);
    logic [23:0] ph;
    int          wc, k;
    for (int i = 0; i <= n; i++) be[i] = '0;
    if (n == 1) be[1].trunc = 1'b1;
    if (n >= 2) begin
      ph = {bw[1][7:0], bw[0]};
      be[1].vld = 1'b1;
      be[1].phs = 1'b1;
      be[1].ph  = ph;
      be[1].ecc = (ecc_ref(ph) != bw[1][13:8]);
      if (!be[1].ecc && ph[5:0] >= 6'h10) begin
        wc = int'(ph[23:8]);
        k  = (wc + 1) / 2;
        for (int j = 0; j < k; j++) begin
          if (2 + j < n) begin
            be[2+j].vld  = 1'b1;
            be[2+j].data = bw[2+j];
            if (j == k - 1) begin
              be[2+j].last = 1'b1;
              be[2+j].half = (wc % 2 == 1);
            end
          end
        end
        if (n < 2 + k + 1) be[n].trunc = 1'b1;
      end
    end
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bw[i];
      exp_q.push_back(be[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(be[n]);
  endtask

  task automatic run_burst(input int n);
    compute_model(n);
    drive(n);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.push_back('0);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic load_t2(input logic [15:0] hdr1);
    bw[0] = 16'h042A; bw[1] = hdr1; bw[2] = 16'h2211; bw[3] = 16'h4433; bw[4] = 16'hBEEF;
  endtask

  // Per-cycle compare against the model queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        vectors++;
        if (cur.vld !== valid_stream || cur.phs !== ph_select || cur.ecc !== ecc_error ||
            cur.last !== data_last || cur.half !== data_half || cur.trunc !== trunc_error ||
            (cur.vld && cur.phs && ph_stream !== cur.ph) ||
            (cur.vld && !cur.phs && data_stream !== cur.data)) begin
          miscompares++;
          $display("FAIL cycle t=%0t: got vld=%b phs=%b ecc=%b last=%b half=%b trunc=%b ph=%h data=%h, expected vld=%b phs=%b ecc=%b last=%b half=%b trunc=%b ph=%h data=%h",
                   $time, valid_stream, ph_select, ecc_error, data_last, data_half, trunc_error,
                   ph_stream, data_stream, cur.vld, cur.phs, cur.ecc, cur.last, cur.half,
                   cur.trunc, cur.ph, cur.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {valid_stream, ph_select, ecc_error, data_last, data_half,
                          trunc_error, data_stream, ph_stream}, 64'd0);
    reset = 1'b0;
    idle(2);

    check("ecc_pin_042a", 64'(ecc_ref(24'h00042A)), 64'h33);
    check("ecc_pin_zero", 64'(ecc_ref(24'h000000)), 64'h00);

    // Short packet, all-zero header (its ECC is zero).
    bw[0] = 16'h0000; bw[1] = 16'h0000;
    compute_model(2);
    check("pin_t1_ph", {39'd0, be[1].vld, be[1].phs, be[1].ph}, {39'd0, 1'b1, 1'b1, 24'h000000});
    check("pin_t1_ecc", 64'(be[1].ecc), 64'd0);
    drive(2);

    // Long RAW8, WC=4.
    load_t2(16'h3300);
    compute_model(5);
    check("pin_t2_ph", 64'(be[1].ph), 64'h00042A);
    check("pin_t2_last", {be[3].data, 6'd0, be[3].last, be[3].half}, {16'h4433, 6'd0, 1'b1, 1'b0});
    drive(5);

    // ECC[7:6] are not part of the check.
    load_t2(16'hF300);
    run_burst(5);

    // Odd WC=3: second payload word is half, CRC_hi word dropped.
    bw[0] = 16'h032A; bw[1] = 16'h1600; bw[2] = 16'h2211; bw[3] = 16'hC033; bw[4] = 16'h00C1;
    compute_model(5);
    check("pin_t3_half", {be[3].last, be[3].half}, 2'b11);
    drive(5);

    // Single-bit ECC error: header flagged, everything after dropped.
    bw[0] = 16'h042A; bw[1] = 16'h3700; bw[2] = 16'h2211; bw[3] = 16'h4433;
    bw[4] = 16'hBEEF; bw[5] = 16'h1234;
    compute_model(6);
    check("pin_t4_ecc", 64'(be[1].ecc), 64'd1);
    drive(6);

    // WC=8 truncated after two payload words, then a normal burst.
    bw[0] = 16'h082A; bw[1] = 16'h3500; bw[2] = 16'h2211; bw[3] = 16'h4433;
    compute_model(4);
    check("pin_t5_trunc", {be[4].trunc, be[3].last}, 2'b10);
    drive(4);
    load_t2(16'h3300);
    run_burst(5);

    // WC=0 long packet, WC=1 long packet, truncation in header, short with trailing words.
    bw[0] = 16'h002A; bw[1] = 16'h1000; bw[2] = 16'hAAAA; bw[3] = 16'h5555;
    run_burst(4);
    bw[0] = 16'h012A; bw[1] = 16'h0A00; bw[2] = 16'hC055; bw[3] = 16'h00C1;
    run_burst(4);
    bw[0] = 16'h042A;
    run_burst(1);
    bw[0] = 16'h0001; bw[1] = 16'h0000; bw[2] = 16'h9999;
    run_burst(3);

    // Async reset in PAYLOAD, then back-to-back bursts.
    load_t2(16'h3300);
    compute_model(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bw[i];
      exp_q.push_back(be[i]);
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.push_back('0);
    #1;
    check("async_reset", {valid_stream, ph_select, ecc_error, data_last, data_half,
                          trunc_error, data_stream, ph_stream}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('0);
    load_t2(16'h3300);
    run_burst(5);
    run_burst(5);
    bw[0] = 16'h0000; bw[1] = 16'h0000;
    run_burst(2);
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
